// File: rtl/aesl_deadlock_report_ctrl.sv
// Deadlock report controller: elects an origin, traces the token around the cycle, latches a sticky report.
// Latency: detect flag -> origin strobe 2 cycles; close -> token_clear 1 cycle; token_clear -> dl_found 1 cycle.
// Backpressure: none on inputs; the report is held in REPORT until report_ack, detect flags ignored meanwhile.
module aesl_deadlock_report_ctrl #(
  parameter int PROC_NUM      = 4,
  parameter int CNT_W         = 8,
  parameter int TRACE_TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_hold_vec,
  output logic                dl_detect_all,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                dl_found,
  output logic [PROC_NUM-1:0] dl_origin,
  output logic [PROC_NUM-1:0] dl_member_mask,
  output logic [CNT_W-1:0]    dl_cycle_len,
  output logic [CNT_W-1:0]    dl_abort_cnt,
  input  logic                report_ack
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_TRACE,
    ST_CLEAR,
    ST_REPORT
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TRACE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [PROC_NUM-1:0] det_q;        // detect flags, one register stage from the fabric
  logic [PROC_NUM-1:0] elect_oh;
  logic [PROC_NUM-1:0] origin_q;
  logic [PROC_NUM-1:0] member_q;
  logic [CNT_W-1:0]    hop_q;
  logic [CNT_W-1:0]    timer_q;
  logic                gap_q;        // previous TRACE cycle had no token after the first hop
  logic [CNT_W-1:0]    abort_q;
  logic [PROC_NUM-1:0] rep_origin_q;
  logic [PROC_NUM-1:0] rep_mask_q;
  logic [CNT_W-1:0]    rep_len_q;
  logic                tok_any;
  logic                close_hit;
  logic                abort_now;

  // Lowest-index flag wins: scan downward so the last write is the lowest set bit.
  always_comb begin
    elect_oh = '0;
    for (int p = PROC_NUM - 1; p >= 0; p--) begin
      if (det_q[p]) begin
        elect_oh    = '0;
        elect_oh[p] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and strobe decode; close beats loss and timeout in the same cycle.
  always_comb begin
    state_d       = state_q;
    dl_detect_all = 1'b0;
    origin_vec    = '0;
    token_clear   = 1'b0;
    dl_found      = 1'b0;
    abort_now     = 1'b0;
    tok_any       = |token_hold_vec;
    close_hit     = (|(dl_detect_vec & origin_q)) && (|(token_hold_vec & origin_q));
    case (state_q)
      ST_IDLE: begin
        if (|det_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        dl_detect_all = 1'b1;
        origin_vec    = origin_q;
        state_d       = ST_TRACE;
      end
      ST_TRACE: begin
        dl_detect_all = 1'b1;
        if (close_hit) begin
          state_d = ST_CLEAR;
        end else if ((!tok_any && gap_q && (hop_q != '0)) || (timer_q == TMO_LAST)) begin
          abort_now = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        dl_detect_all = 1'b1;
        token_clear   = 1'b1;
        state_d       = ST_REPORT;
      end
      ST_REPORT: begin
        dl_detect_all = 1'b1;
        dl_found      = 1'b1;
        if (report_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Trace datapath, abort counter and sticky report registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      det_q        <= '0;
      origin_q     <= '0;
      member_q     <= '0;
      hop_q        <= '0;
      timer_q      <= '0;
      gap_q        <= 1'b0;
      abort_q      <= '0;
      rep_origin_q <= '0;
      rep_mask_q   <= '0;
      rep_len_q    <= '0;
    end else begin
      // Flags raised while a report is pending are dropped, not queued.
      det_q <= (state_q == ST_REPORT) ? '0 : dl_detect_vec;
      case (state_q)
        ST_IDLE: begin
          if (|det_q) origin_q <= elect_oh;
        end
        ST_ARM: begin
          member_q <= origin_q;
          hop_q    <= '0;
          timer_q  <= '0;
          gap_q    <= 1'b0;
        end
        ST_TRACE: begin
          timer_q <= timer_q + CNT_ONE;
          gap_q   <= !tok_any && (hop_q != '0);
          if (tok_any) begin
            member_q <= member_q | token_hold_vec;
            if (hop_q != '1) hop_q <= hop_q + CNT_ONE;
          end
          if (abort_now && (abort_q != '1)) abort_q <= abort_q + CNT_ONE;
        end
        ST_CLEAR: begin
          rep_origin_q <= origin_q;
          rep_mask_q   <= member_q;
          rep_len_q    <= hop_q;
        end
        ST_REPORT: begin
          if (report_ack) begin
            rep_origin_q <= '0;
            rep_mask_q   <= '0;
            rep_len_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dl_origin      = rep_origin_q;
  assign dl_member_mask = rep_mask_q;
  assign dl_cycle_len   = rep_len_q;
  assign dl_abort_cnt   = abort_q;

endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Bench for aesl_deadlock_report_ctrl: election, trace close/report, loss and timeout aborts, resets.
// Latency: expectations queued at stimulus time and popped when the DUT strobes.
// Backpressure: report_ack driven explicitly by the bench.
module tb_aesl_deadlock_report_ctrl;

  typedef struct packed {
    logic [3:0] o;
    logic [3:0] m;
    logic [7:0] l;
  } rep_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] dl_detect_vec;
  logic [3:0] token_hold_vec;
  logic       report_ack;
  logic       dl_detect_all;
  logic [3:0] origin_vec;
  logic       token_clear;
  logic       dl_found;
  logic [3:0] dl_origin;
  logic [3:0] dl_member_mask;
  logic [7:0] dl_cycle_len;
  logic [7:0] dl_abort_cnt;

  int   total = 0;
  int   bad = 0;
  int   exp_aborts = 0;
  logic [3:0] exp_org[$];
  rep_t       exp_rep[$];

  aesl_deadlock_report_ctrl #(.PROC_NUM(4), .CNT_W(8), .TRACE_TIMEOUT(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .dl_detect_vec (dl_detect_vec),
    .token_hold_vec(token_hold_vec),
    .dl_detect_all (dl_detect_all),
    .origin_vec    (origin_vec),
    .token_clear   (token_clear),
    .dl_found      (dl_found),
    .dl_origin     (dl_origin),
    .dl_member_mask(dl_member_mask),
    .dl_cycle_len  (dl_cycle_len),
    .dl_abort_cnt  (dl_abort_cnt),
    .report_ack    (report_ack)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic bump_abort;
    if (exp_aborts < 255) exp_aborts++;
  endtask

  // Drive a detect pulse, then wait (bounded) for the origin strobe.
  task automatic elect(input logic [3:0] det_in, input logic [3:0] exp_o);
    int   lat;
    bit   seen;
    logic [3:0] o;
    dl_detect_vec = det_in;
    exp_org.push_back(exp_o);
    lat  = 0;
    seen = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      tick;
      dl_detect_vec = 4'b0000;
      lat = i;
      if (origin_vec != 4'b0000) seen = 1;
    end
    o = exp_org.pop_front();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL origin_strobe_timeout got=none want=%b", o);
    end else begin
      total++;
      if (origin_vec !== o) begin
        bad++;
        $display("FAIL origin_vec got=%b want=%b", origin_vec, o);
      end
      total++;
      if (lat !== 2) begin
        bad++;
        $display("FAIL origin_latency got=%0d want=2", lat);
      end
      total++;
      if (dl_detect_all !== 1'b1) begin
        bad++;
        $display("FAIL detect_all_arm got=%b want=1", dl_detect_all);
      end
    end
  endtask

  // From the ARM cycle: walk t0,t1,t2 then return to origin with its detect flag up.
  task automatic do_close(input logic [3:0] o, input logic [3:0] t0, input logic [3:0] t1,
                          input logic [3:0] t2, output rep_t got_exp);
    rep_t e;
    tick; token_hold_vec = t0;
    tick; token_hold_vec = t1;
    tick; token_hold_vec = t2;
    tick; token_hold_vec = o; dl_detect_vec = o;
    exp_rep.push_back('{o: o, m: (o | t0 | t1 | t2), l: 8'd4});
    tick; token_hold_vec = 4'b0000; dl_detect_vec = 4'b0000;
    total++;
    if (token_clear !== 1'b1 || dl_found !== 1'b0) begin
      bad++;
      $display("FAIL token_clear_pulse got=clr%b found%b want=clr1 found0", token_clear, dl_found);
    end
    tick;
    total++;
    if (token_clear !== 1'b0 || dl_found !== 1'b1) begin
      bad++;
      $display("FAIL report_entry got=clr%b found%b want=clr0 found1", token_clear, dl_found);
    end
    e = exp_rep.pop_front();
    got_exp = e;
    total++;
    if (dl_origin !== e.o || dl_member_mask !== e.m || dl_cycle_len !== e.l) begin
      bad++;
      $display("FAIL report_fields got=%b/%b/%0d want=%b/%b/%0d",
               dl_origin, dl_member_mask, dl_cycle_len, e.o, e.m, e.l);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    dl_detect_vec = 4'b0000;
    token_hold_vec = 4'b0000;
    report_ack = 1'b0;
    repeat (3) tick;
    total++;
    if ({dl_detect_all, origin_vec, token_clear, dl_found, dl_origin, dl_member_mask,
         dl_cycle_len, dl_abort_cnt} !== 31'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {dl_detect_all, origin_vec, token_clear,
               dl_found, dl_origin, dl_member_mask, dl_cycle_len, dl_abort_cnt});
    end
    reset = 1'b1;
    tick;
    // A stray ack outside REPORT must do nothing.
    report_ack = 1'b1;
    tick;
    report_ack = 1'b0;
    total++;
    if (dl_detect_all !== 1'b0 || dl_found !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got=all%b found%b want=0 0", dl_detect_all, dl_found);
    end
  endtask

  task automatic test_close_report;
    rep_t e;
    bit   strobed;
    elect(4'b0100, 4'b0100);
    do_close(4'b0100, 4'b0100, 4'b0001, 4'b1000, e);
    // Detect flags during REPORT are ignored; report must hold.
    dl_detect_vec = 4'b0001;
    repeat (3) tick;
    total++;
    if (dl_found !== 1'b1 || dl_origin !== e.o || dl_member_mask !== e.m || dl_cycle_len !== e.l) begin
      bad++;
      $display("FAIL report_hold got=%b/%b/%b/%0d want=1/%b/%b/%0d",
               dl_found, dl_origin, dl_member_mask, dl_cycle_len, e.o, e.m, e.l);
    end
    report_ack = 1'b1;
    dl_detect_vec = 4'b0000;
    tick;
    report_ack = 1'b0;
    total++;
    if ({dl_found, dl_detect_all, dl_origin, dl_member_mask, dl_cycle_len} !== 18'd0) begin
      bad++;
      $display("FAIL report_ack_clear got=%h want=0",
               {dl_found, dl_detect_all, dl_origin, dl_member_mask, dl_cycle_len});
    end
    strobed = 0;
    repeat (4) begin
      tick;
      if (origin_vec !== 4'b0000 || dl_detect_all !== 1'b0) strobed = 1;
    end
    total++;
    if (strobed) begin
      bad++;
      $display("FAIL report_detect_ignored got=strobe want=idle");
    end
    total++;
    if (dl_abort_cnt !== 8'(exp_aborts)) begin
      bad++;
      $display("FAIL abort_cnt_after_close got=%0d want=%0d", dl_abort_cnt, exp_aborts);
    end
  endtask

  task automatic test_loss;
    bit cleared;
    elect(4'b1010, 4'b0010);
    cleared = 0;
    tick; token_hold_vec = 4'b0100;
    tick; token_hold_vec = 4'b0000;
    if (token_clear || dl_found) cleared = 1;
    tick;
    if (token_clear || dl_found) cleared = 1;
    total++;
    if (dl_detect_all !== 1'b1) begin
      bad++;
      $display("FAIL loss_not_early got=%b want=1", dl_detect_all);
    end
    tick;
    if (token_clear || dl_found) cleared = 1;
    bump_abort();
    total++;
    if (dl_detect_all !== 1'b0 || dl_abort_cnt !== 8'(exp_aborts)) begin
      bad++;
      $display("FAIL loss_abort got=all%b cnt%0d want=all0 cnt%0d", dl_detect_all, dl_abort_cnt, exp_aborts);
    end
    total++;
    if (cleared) begin
      bad++;
      $display("FAIL loss_no_clear got=clear_or_found want=none");
    end
  endtask

  task automatic test_timeout;
    int cnt;
    bit cleared;
    elect(4'b0001, 4'b0001);
    token_hold_vec = 4'b0010;
    cnt = 0;
    cleared = 0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (token_clear || dl_found) cleared = 1;
      if (dl_detect_all) cnt++;
      else break;
    end
    token_hold_vec = 4'b0000;
    bump_abort();
    total++;
    if (cnt !== 64) begin
      bad++;
      $display("FAIL timeout_cycles got=%0d want=64", cnt);
    end
    total++;
    if (dl_abort_cnt !== 8'(exp_aborts) || cleared) begin
      bad++;
      $display("FAIL timeout_abort got=cnt%0d clr%b want=cnt%0d clr0", dl_abort_cnt, cleared, exp_aborts);
    end
  endtask

  task automatic test_abort_saturation;
    for (int n = 0; n < 256; n++) begin
      dl_detect_vec = 4'b0001;
      tick; dl_detect_vec = 4'b0000;
      tick;
      tick; token_hold_vec = 4'b0001;
      tick; token_hold_vec = 4'b0000;
      tick;
      tick;
      tick;
      bump_abort();
    end
    total++;
    if (dl_abort_cnt !== 8'(exp_aborts)) begin
      bad++;
      $display("FAIL abort_saturate got=%0d want=%0d", dl_abort_cnt, exp_aborts);
    end
  endtask

  task automatic test_reset_mid;
    rep_t e;
    elect(4'b0100, 4'b0100);
    tick; token_hold_vec = 4'b0010;
    tick;
    #2 reset = 1'b0;
    #1;
    exp_aborts = 0;
    total++;
    if ({dl_detect_all, origin_vec, token_clear, dl_found, dl_abort_cnt} !== 15'd0) begin
      bad++;
      $display("FAIL reset_in_trace got=%h want=0", {dl_detect_all, origin_vec, token_clear, dl_found, dl_abort_cnt});
    end
    token_hold_vec = 4'b0000;
    @(posedge clock); #1 reset = 1'b1;
    tick;
    total++;
    if (origin_vec !== 4'b0000 || token_clear !== 1'b0 || dl_detect_all !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_quiet got=%b/%b/%b want=0/0/0", origin_vec, token_clear, dl_detect_all);
    end
    elect(4'b1000, 4'b1000);
    do_close(4'b1000, 4'b0001, 4'b0010, 4'b0100, e);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({dl_found, dl_detect_all, dl_origin, dl_member_mask, dl_cycle_len} !== 18'd0) begin
      bad++;
      $display("FAIL reset_in_report got=%h want=0", {dl_found, dl_detect_all, dl_origin, dl_member_mask, dl_cycle_len});
    end
    @(posedge clock); #1 reset = 1'b1;
    tick;
    elect(4'b0110, 4'b0010);
  endtask

  initial begin
    test_reset();
    test_close_report();
    test_loss();
    test_timeout();
    test_abort_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aesl_deadlock_report_ctrl.md
Name: aesl_deadlock_report_ctrl

Overview:
- Central controller directly downstream of the per-process deadlock detect units in the HLS co-simulation fabric.
- Collects every unit's deadlock flag and elects one origin process.
- Drives the global detect flag, the origin strobe and token_clear back to the units, then traces the token around the cycle.
- Latches a sticky report (origin, member mask, cycle length) for the testbench monitor.

Parameters:
PROC_NUM, 4, number of monitored processes; width of all per-process vectors
CNT_W, 8, width of hop and timeout counters
TRACE_TIMEOUT, 64, max TRACE cycles before abort; must be < 2^CNT_W

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
dl_detect_vec  in  PROC_NUM  per-process deadlock flag from each detect unit
token_hold_vec  in  PROC_NUM  bit p = OR of process p's token_out_vec
dl_detect_all  out  1  global "deadlock under trace" flag, broadcast to every unit
origin_vec  out  PROC_NUM  one-hot, one-cycle origin strobe to the elected unit
token_clear  out  1  one-cycle pulse that kills token circulation
dl_found  out  1  sticky: deadlock cycle confirmed
dl_origin  out  PROC_NUM  one-hot origin of the confirmed cycle
dl_member_mask  out  PROC_NUM  processes the token visited, origin included
dl_cycle_len  out  CNT_W  hops taken to return to the origin
dl_abort_cnt  out  CNT_W  saturating count of aborted traces
report_ack  in  1  monitor acknowledge; clears the report

Behaviour:
- Reset (asynchronous, active-low), all outputs and state:
  - state = IDLE; all outputs 0; counters 0; origin register 0.
  - Reset asserted mid-trace drops to IDLE immediately; the next cycle after release shows no strobes.
- FSM states: IDLE, ARM, TRACE, CLEAR, REPORT.
- IDLE:
  - dl_detect_all = 0.
  - If dl_detect_vec != 0, register origin = lowest set bit (lowest index wins on simultaneous flags) and go to ARM.
- ARM (exactly one cycle):
  - origin_vec = one-hot origin; dl_detect_all = 1.
  - member_mask = origin; hop = 0; timer = 0.
  - Next state: TRACE.
- TRACE:
  - dl_detect_all = 1; timer increments every cycle.
  - Each cycle with token_hold_vec != 0: member_mask |= token_hold_vec; hop += 1, saturating at all-ones.
  - Close condition: dl_detect_vec & origin is nonzero AND token_hold_vec & origin is nonzero in the same cycle → CLEAR.
  - Loss condition: token_hold_vec == 0 for 2 consecutive cycles after the first hop → abort.
  - Timeout: timer == TRACE_TIMEOUT-1 without close → abort.
  - Abort action: dl_abort_cnt += 1 (saturating); go to IDLE. No token_clear is issued.
  - Close has priority over loss and timeout in the same cycle.
- CLEAR (one cycle):
  - token_clear = 1; dl_detect_all stays 1.
  - Latch dl_origin = origin, dl_member_mask = member_mask, dl_cycle_len = hop.
  - Next state: REPORT.
- REPORT:
  - dl_found = 1 and dl_detect_all = 1; report outputs held stable.
  - dl_detect_vec is ignored.
  - report_ack = 1 → next cycle: dl_found = 0, report outputs cleared, state IDLE.
  - A fresh detection can therefore start no earlier than the cycle after leaving REPORT.
- report_ack is ignored in all states other than REPORT.
- Latency:
  - First dl_detect_vec bit to origin_vec strobe: 2 cycles.
  - Close cycle to token_clear: 1 cycle.
  - token_clear to dl_found: 1 cycle.
- Width rules:
  - All per-process vectors are PROC_NUM wide, bit p = process p.
  - Origin election is a priority encoder to one-hot, never an encoded index.

Test Plan:
- Reset → all outputs 0. Then dl_detect_vec=4'b0100 → ARM with origin_vec=4'b0100 exactly 2 cycles later, dl_detect_all=1 from the ARM cycle onward.
- Simultaneous dl_detect_vec=4'b1010 → origin elected = 4'b0010.
- Token walk 2→0→3 over 3 cycles, then token at 2 with dl_detect_vec[2]=1 (origin 4'b0100):
  - token_clear pulses for 1 cycle.
  - Next cycle: dl_found=1, dl_member_mask=4'b1101, dl_cycle_len=4, dl_origin=4'b0100.
  - report_ack → all cleared one cycle later.
- Token disappears for 2 cycles mid-trace → back to IDLE, dl_abort_cnt=1, no token_clear, dl_found stays 0.
- Token circulates without ever closing → abort after exactly TRACE_TIMEOUT=64 TRACE cycles; 256 forced aborts → dl_abort_cnt saturates at 255.
- Reset asserted during TRACE and during REPORT → outputs 0 asynchronously; after release, a new detection re-elects the origin correctly.
